// File: rtl/qbert_only_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : qbert_only_copy_master
// Brief    : Avalon-MM master block-copy engine; reads a run of words into a
//            small buffer, then writes them out. QBERT_COPY_FILL_EN adds
//            pattern-fill mode.
// Revision : 1.0 - initial release
// ============================================================================
module qbert_only_copy_master #(
    parameter int ADDR_W    = 13,
    parameter int LEN_W     = 13,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_fill,
    input  logic [31:0]       cmd_pattern,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic [31:0]       avm_readdata
);
    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_W-1:0]    r_src;
    logic [ADDR_W-1:0]    r_dst;
    logic [LEN_W-1:0]     r_remaining;
    logic [c_CNT_W-1:0]   r_issued;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [31:0]          r_buf [BUF_DEPTH];

    logic                 w_accept;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [c_CNT_W-1:0]   w_chunk;
    logic                 w_last_issue;
    logic                 w_fill_cmd;
    logic                 w_fill;
    logic [31:0]          w_wr_data;

    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_rd_fire    = avm_read && !avm_waitrequest;
    assign w_wr_fire    = avm_write && !avm_waitrequest;
    // Beats with nothing outstanding are stale responses from before a reset.
    assign w_push       = avm_readdatavalid && (r_outstanding != '0);
    assign w_pop        = w_wr_fire && !w_fill;
    assign w_chunk      = (r_remaining > LEN_W'(BUF_DEPTH)) ? c_CNT_W'(BUF_DEPTH)
                                                            : c_CNT_W'(r_remaining);
    assign w_last_issue = ((r_issued + c_CNT_W'(1)) == w_chunk);

`ifdef QBERT_COPY_FILL_EN
    logic        r_fill;
    logic [31:0] r_pattern;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill    <= 1'b0;
            r_pattern <= '0;
        end else if (w_accept) begin
            r_fill    <= cmd_fill;
            r_pattern <= cmd_pattern;
        end
    end

    assign w_fill_cmd = cmd_fill;
    assign w_fill     = r_fill;
    assign w_wr_data  = r_fill ? r_pattern : r_buf[r_rd_ptr];
`else
    logic w_unused_fill;
    assign w_unused_fill = cmd_fill ^ (^cmd_pattern);
    assign w_fill_cmd    = 1'b0;
    assign w_fill        = 1'b0;
    assign w_wr_data     = r_buf[r_rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        cmd_ready     = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        done          = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0)   w_state_next = S_DONE;
                    else if (w_fill_cmd) w_state_next = S_WRITE;
                    else                 w_state_next = S_READ;
                end
            end
            S_READ: begin
                avm_read    = 1'b1;
                avm_address = r_src;
                if (w_rd_fire && w_last_issue) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave as soon as the final beat lands so writes start next cycle.
                if ((r_outstanding == '0) || ((r_outstanding == c_CNT_W'(1)) && w_push))
                    w_state_next = S_WRITE;
            end
            S_WRITE: begin
                avm_write     = 1'b1;
                avm_address   = r_dst;
                avm_writedata = w_wr_data;
                if (w_wr_fire) begin
                    if (r_remaining == LEN_W'(1))                 w_state_next = S_DONE;
                    else if (!w_fill && (r_count == c_CNT_W'(1))) w_state_next = S_READ;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy           = (r_state != S_IDLE);
    assign avm_chipselect = avm_read | avm_write;
    assign avm_byteenable = 4'hF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src         <= '0;
            r_dst         <= '0;
            r_remaining   <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_accept) begin
                r_src       <= cmd_src;
                r_dst       <= cmd_dst;
                r_remaining <= cmd_len;
            end
            if (w_rd_fire) begin
                r_src    <= r_src + ADDR_W'(1);
                r_issued <= w_last_issue ? '0 : r_issued + c_CNT_W'(1);
            end
            if (w_wr_fire) begin
                r_dst       <= r_dst + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_outstanding <= r_outstanding + c_CNT_W'(w_rd_fire) - c_CNT_W'(w_push);
            r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr_ptr] <= avm_readdata;
    end

endmodule
`default_nettype wire
